// File: rtl/crossbar_controller.sv
// Configuration controller for a 4x4 crossbar: shadow routing table loaded by
// route writes, atomically committed to the active table driving the mux selects.
module crossbar_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       w,
  input  logic       s,
  input  logic [5:0] in,
  output logic [7:0] out_sel,
  output logic [3:0] out_en,
  output logic       locked,
  output logic       err
);

  // Shadow table; the active table lives directly in out_sel/out_en.
  logic [7:0] shadow_sel;
  logic [3:0] shadow_en;

  logic       route_wr;
  logic       ctrl_wr;
  logic [2:0] sel_lsb;

  assign route_wr = w && !s;
  assign ctrl_wr  = w && s;
  assign sel_lsb  = {in[5:4], 1'b0};

  // All control bits act in one edge: commit samples the pre-edge shadow, so a
  // shadow clear in the same word only affects the following commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_sel <= 8'h00;
      shadow_en  <= 4'h0;
      out_sel    <= 8'h00;
      out_en     <= 4'h0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (route_wr) begin
        if (locked) begin
          err <= 1'b1;
        end else begin
          shadow_sel[sel_lsb +: 2] <= in[3:2];
          shadow_en[in[5:4]]       <= in[1];
        end
      end
      if (ctrl_wr) begin
        if (in[5]) err <= 1'b0;
        if (in[2]) begin
          out_sel <= 8'h00;
          out_en  <= 4'h0;
        end else if (in[0]) begin
          out_sel <= shadow_sel;
          out_en  <= shadow_en;
        end
        if (in[1]) begin
          shadow_sel <= 8'h00;
          shadow_en  <= 4'h0;
        end
        if (in[3])      locked <= 1'b1;
        else if (in[4]) locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crossbar_controller.sv
// Self-checking bench for crossbar_controller: scenario tasks push expected
// {out_sel, out_en, locked, err} words and compare them as the DUT responds.
module tb_crossbar_controller;

  localparam int W = 14;

  logic       clk;
  logic       reset;
  logic       w;
  logic       s;
  logic [5:0] in;
  logic [7:0] out_sel;
  logic [3:0] out_en;
  logic       locked;
  logic       err;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] got_v;
  int           total_cnt;
  int           pass_cnt;

  crossbar_controller dut (
    .clk     (clk),
    .reset   (reset),
    .w       (w),
    .s       (s),
    .in      (in),
    .out_sel (out_sel),
    .out_en  (out_en),
    .locked  (locked),
    .err     (err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(input logic [7:0] sel, input logic [3:0] en,
                                        input logic lk, input logic er);
    return {sel, en, lk, er};
  endfunction

  // Driver: present one command for one rising edge, sample 1 time unit later.
  task automatic send(input logic s_v, input logic [5:0] in_v);
    @(negedge clk);
    w  = 1'b1;
    s  = s_v;
    in = in_v;
    @(posedge clk);
    #1;
    w  = 1'b0;
    s  = 1'($urandom_range(0, 1));
    in = 6'($urandom_range(0, 63));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    w  = 1'b0;
    s  = 1'($urandom_range(0, 1));
    in = 6'($urandom_range(0, 63));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_q.push_back(pack(8'h00, 4'h0, 1'b0, 1'b0));
    got_v = {out_sel, out_en, locked, err};
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (got_v !== exp_v) $display("FAIL reset_state got=%h exp=%h", got_v, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_route_commit();
    exp_q.push_back(pack(8'h00, 4'h0, 1'b0, 1'b0));
    send(1'b0, 6'b011110);
    got_v = {out_sel, out_en, locked, err};
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (got_v !== exp_v) $display("FAIL route_no_effect got=%h exp=%h", got_v, exp_v);
    else pass_cnt++;

    exp_q.push_back(pack(8'h0C, 4'b0010, 1'b0, 1'b0));
    send(1'b1, 6'b000001);
    got_v = {out_sel, out_en, locked, err};
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (got_v !== exp_v) $display("FAIL route_commit got=%h exp=%h", got_v, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_lock_commit();
    logic        s_seq[5];
    logic [5:0]  in_seq[5];
    string       names[5];
    // output 2 <- input 1; lock+commit; locked write; unlock+clear err; commit
    s_seq[0] = 1'b0; in_seq[0] = 6'b100110; names[0] = "lock_pre_route";
    s_seq[1] = 1'b1; in_seq[1] = 6'b001001; names[1] = "lock_and_commit";
    s_seq[2] = 1'b0; in_seq[2] = 6'b000110; names[2] = "write_while_locked";
    s_seq[3] = 1'b1; in_seq[3] = 6'b110000; names[3] = "unlock_clear_err";
    s_seq[4] = 1'b1; in_seq[4] = 6'b000001; names[4] = "shadow_kept_when_locked";
    exp_q.push_back(pack(8'h0C, 4'b0010, 1'b0, 1'b0));
    exp_q.push_back(pack(8'h1C, 4'b0110, 1'b1, 1'b0));
    exp_q.push_back(pack(8'h1C, 4'b0110, 1'b1, 1'b1));
    exp_q.push_back(pack(8'h1C, 4'b0110, 1'b0, 1'b0));
    exp_q.push_back(pack(8'h1C, 4'b0110, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      send(s_seq[i], in_seq[i]);
      got_v = {out_sel, out_en, locked, err};
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (got_v !== exp_v) $display("FAIL %s got=%h exp=%h", names[i], got_v, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_commit_clear_shadow();
    logic        s_seq[3];
    logic [5:0]  in_seq[3];
    string       names[3];
    s_seq[0] = 1'b0; in_seq[0] = 6'b111010; names[0] = "ccs_route";
    s_seq[1] = 1'b1; in_seq[1] = 6'b000011; names[1] = "commit_and_clear_shadow";
    s_seq[2] = 1'b1; in_seq[2] = 6'b000001; names[2] = "commit_cleared_shadow";
    exp_q.push_back(pack(8'h1C, 4'b0110, 1'b0, 1'b0));
    exp_q.push_back(pack(8'h9C, 4'b1110, 1'b0, 1'b0));
    exp_q.push_back(pack(8'h00, 4'b0000, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      send(s_seq[i], in_seq[i]);
      got_v = {out_sel, out_en, locked, err};
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (got_v !== exp_v) $display("FAIL %s got=%h exp=%h", names[i], got_v, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_clear_active();
    logic        s_seq[4];
    logic [5:0]  in_seq[4];
    string       names[4];
    s_seq[0] = 1'b0; in_seq[0] = 6'b001010; names[0] = "ca_route";
    s_seq[1] = 1'b1; in_seq[1] = 6'b000001; names[1] = "ca_commit";
    s_seq[2] = 1'b1; in_seq[2] = 6'b000101; names[2] = "clear_active_beats_commit";
    s_seq[3] = 1'b1; in_seq[3] = 6'b000001; names[3] = "shadow_survives_clear_active";
    exp_q.push_back(pack(8'h00, 4'b0000, 1'b0, 1'b0));
    exp_q.push_back(pack(8'h02, 4'b0001, 1'b0, 1'b0));
    exp_q.push_back(pack(8'h00, 4'b0000, 1'b0, 1'b0));
    exp_q.push_back(pack(8'h02, 4'b0001, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      send(s_seq[i], in_seq[i]);
      got_v = {out_sel, out_en, locked, err};
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (got_v !== exp_v) $display("FAIL %s got=%h exp=%h", names[i], got_v, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_lock_unlock();
    exp_q.push_back(pack(8'h02, 4'b0001, 1'b1, 1'b0));
    send(1'b1, 6'b011000);
    got_v = {out_sel, out_en, locked, err};
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (got_v !== exp_v) $display("FAIL lock_wins got=%h exp=%h", got_v, exp_v);
    else pass_cnt++;

    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pack(8'h02, 4'b0001, 1'b1, 1'b0));
      idle_cycle();
      got_v = {out_sel, out_en, locked, err};
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (got_v !== exp_v) $display("FAIL idle_hold%0d got=%h exp=%h", i, got_v, exp_v);
      else pass_cnt++;
    end

    exp_q.push_back(pack(8'h02, 4'b0001, 1'b1, 1'b0));
    send(1'b1, 6'b000000);
    got_v = {out_sel, out_en, locked, err};
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (got_v !== exp_v) $display("FAIL ctrl_noop got=%h exp=%h", got_v, exp_v);
    else pass_cnt++;

    // Clear shadow while locked is honoured; the next commit shows it.
    exp_q.push_back(pack(8'h02, 4'b0001, 1'b1, 1'b0));
    exp_q.push_back(pack(8'h00, 4'b0000, 1'b1, 1'b0));
    send(1'b1, 6'b000010);
    got_v = {out_sel, out_en, locked, err};
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (got_v !== exp_v) $display("FAIL clear_shadow_locked got=%h exp=%h", got_v, exp_v);
    else pass_cnt++;
    send(1'b1, 6'b000001);
    got_v = {out_sel, out_en, locked, err};
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (got_v !== exp_v) $display("FAIL commit_after_clear_locked got=%h exp=%h", got_v, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    // Build nonzero state: unlock, route+commit, lock, set err.
    send(1'b1, 6'b010000);
    send(1'b0, 6'b101110);
    send(1'b1, 6'b001001);
    exp_q.push_back(pack(8'h30, 4'b0100, 1'b1, 1'b1));
    send(1'b0, 6'b000010);
    got_v = {out_sel, out_en, locked, err};
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (got_v !== exp_v) $display("FAIL pre_reset_state got=%h exp=%h", got_v, exp_v);
    else pass_cnt++;

    @(posedge clk);
    #3;
    reset = 1'b0;
    exp_q.push_back(pack(8'h00, 4'h0, 1'b0, 1'b0));
    #1;
    got_v = {out_sel, out_en, locked, err};
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (got_v !== exp_v) $display("FAIL async_reset got=%h exp=%h", got_v, exp_v);
    else pass_cnt++;

    // Reset holds state even with commands presented on a clock edge.
    exp_q.push_back(pack(8'h00, 4'h0, 1'b0, 1'b0));
    send(1'b1, 6'b001001);
    got_v = {out_sel, out_en, locked, err};
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (got_v !== exp_v) $display("FAIL reset_hold got=%h exp=%h", got_v, exp_v);
    else pass_cnt++;

    @(negedge clk);
    reset = 1'b1;
    // Shadow must have been cleared by reset.
    exp_q.push_back(pack(8'h00, 4'h0, 1'b0, 1'b0));
    send(1'b1, 6'b000001);
    got_v = {out_sel, out_en, locked, err};
    exp_v = exp_q.pop_front();
    total_cnt++;
    if (got_v !== exp_v) $display("FAIL shadow_after_reset got=%h exp=%h", got_v, exp_v);
    else pass_cnt++;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    reset     = 1'b0;
    w         = 1'b0;
    s         = 1'b0;
    in        = 6'h00;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_route_commit();
    test_lock_commit();
    test_commit_clear_shadow();
    test_clear_active();
    test_lock_unlock();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/crossbar_controller.md
Name: crossbar_controller

Overview:
Configuration controller for a 4x4 crossbar switch. It accepts 6-bit command words, qualified by a write strobe and a mode select, into a shadow routing table. On a commit command it transfers that table atomically to the active table that drives the crossbar mux selects. It also provides lock/unlock protection and a sticky error flag.

Parameters:
None. Port count is fixed at 4 by the 6-bit command encoding.

Ports:
clk        input   1  system clock; all state updates on rising edge
reset      input   1  asynchronous, active-low reset
w          input   1  command write strobe; command accepted on a rising clk edge when w=1
s          input   1  command mode: 0 = route write, 1 = control command
in         input   6  command word; field meaning depends on s
out_sel    output  8  active input select per output port; out_sel[2k+1:2k] = input index feeding output k
out_en     output  4  active enable per output port; out_en[k]=0 means output k is driven to zero by the crossbar
locked     output  1  1 while route writes are blocked
err        output  1  sticky error flag

Behaviour:
- Reset (reset=0, asynchronous):
  - shadow and active tables cleared: all selects 0, all enables 0.
  - out_sel=8'h00, out_en=4'h0, locked=0, err=0.
  - Takes effect immediately, including mid-operation; state holds until reset deasserts.
- All outputs are registered directly from the active table and status flops. No combinational paths from inputs.
- w=0: no state change.
- Route write (w=1, s=0):
  - in[5:4] = output index k; in[3:2] = input index; in[1] = enable; in[0] reserved, ignored.
  - If locked=0: shadow select[k] <= in[3:2] and shadow enable[k] <= in[1].
  - If locked=1: shadow is unchanged and err <= 1.
  - Active table is never changed by a route write. Outputs change only on commit.
- Control command (w=1, s=1): each bit is an independent action. When several bits are set they are applied in the same cycle, with this precedence:
  - in[5] clear error: err <= 0. Takes priority over any err set in the same cycle.
  - in[2] clear active: active table <= all zero. Takes priority over in[0].
  - in[1] clear shadow: shadow <= all zero. Applied after commit, so in[0]+in[1] commits the old shadow, then clears the shadow.
  - in[0] commit: active <= shadow value as it was before this edge. Visible on out_sel/out_en the cycle after acceptance (latency 1).
  - in[3] lock: locked <= 1.
  - in[4] unlock: locked <= 0. Lock wins if in[3] and in[4] are both set.
  - Clear shadow (in[1]) while locked is honoured. Lock blocks route writes only.
  - Control word 6'b000000 is a no-op.
- Commit while locked is allowed. The active table takes the shadow contents.
- Multiple outputs may select the same input (broadcast is legal). No conflict checking.
- err is set only by a route write while locked. It remains 1 until cleared by in[5] or reset.

Test Plan:
- Reset: assert reset=0 mid-run with nonzero tables -> out_sel=00, out_en=0, locked=0, err=0 immediately, without waiting for a clock edge.
- Route then commit:
  - write s=0, in=6'b011110 (output 1 <- input 3, enabled) -> out_en/out_sel unchanged.
  - then s=1, in=6'b000001 -> next cycle out_sel[3:2]=3, out_en=4'b0010.
- Lock and commit in one word:
  - w=1, s=1, in=6'b001001 -> locked=1 and active=shadow next cycle.
  - subsequent s=0 route write -> shadow unchanged, err=1.
  - then s=1, in=6'b110000 (unlock + clear err) -> locked=0, err=0.
- Commit plus clear shadow:
  - load route, then s=1, in=6'b000011 -> active holds route.
  - a further commit (in=6'b000001) -> active all zero.
- Clear active priority:
  - s=1, in=6'b000101 -> active zero regardless of shadow.
- Lock/unlock together:
  - s=1, in=6'b011000 -> locked=1.
  - w=0 for several cycles -> no state change.
